multicycle_ctrl: RTL

//  Multi-cycle control FSM sitting directly upstream of the integer datapath: consumes opcode/func3/func7b50/exdone
//  and drives every datapath control input (pcmuxctl, pcnextctl, instrre, regre, regwe, aluctl, mulstart, mulctl, ifuresctl).

---
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/multicycle_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: decode inputs and datapath control outputs between the controller and the integer datapath.
interface multicycle_ctrl_if #(
  parameter int PCMUX_N     = 2,
  parameter int IFURESCTL_N = 2,
  parameter int CNT_W       = 32
);
  logic [6:0]                       opcode;
  logic [2:0]                       func3;
  logic [1:0]                       func7b50;
  logic                             exdone;
  logic [$clog2(PCMUX_N)-1:0]       pcmuxctl;
  logic                             pcnextctl;
  logic                             instrre;
  logic                             regre;
  logic                             regwe;
  logic [3:0]                       aluctl;
  logic                             mulstart;
  logic [1:0]                       mulctl;
  logic [$clog2(IFURESCTL_N)-1:0]   ifuresctl;
  logic                             trap;
  logic                             trapcause;
  logic [CNT_W-1:0]                 instret;
  modport master (
    input  opcode, func3, func7b50, exdone,
    output pcmuxctl, pcnextctl, instrre, regre, regwe, aluctl, mulstart, mulctl, ifuresctl, trap, trapcause, instret
  );
  modport slave (
    output opcode, func3, func7b50, exdone,
    input  pcmuxctl, pcnextctl, instrre, regre, regwe, aluctl, mulstart, mulctl, ifuresctl, trap, trapcause, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EX/WB sequencer for RV32I R-type and RV32M MUL*, with a sticky trap on
// illegal encodings or a multiplier that never reports done.
module multicycle_ctrl #(
  parameter int PCMUX_N     = 2,
  parameter int IFURESCTL_N = 2,
  parameter int EX_TIMEOUT  = 64,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  multicycle_ctrl_if.master bus
);
  localparam int IW = $clog2(IFURESCTL_N);
  localparam int TW = $clog2(EX_TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EX_START, S_EX_WAIT, S_WB, S_TRAP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_aluctl, w_aluctl;
  logic [1:0] r_mulctl;
  logic [IW-1:0] r_ifures;
  logic [TW-1:0] r_cnt;
  logic [CNT_W-1:0] r_instret;
  logic r_trapcause;
  logic w_mop, w_legal, w_timeout;
  assign w_mop = bus.func7b50 == 2'b01;
  assign w_legal = bus.opcode == 7'b0110011 &&
                   (bus.func7b50 == 2'b00 ||
                    (bus.func7b50 == 2'b10 && (bus.func3 == 3'd0 || bus.func3 == 3'd5)) ||
                    (w_mop && !bus.func3[2]));
  assign w_timeout = r_cnt == TW'(EX_TIMEOUT - 1);
  always_comb begin
    w_aluctl = 4'd0;
    case (bus.func3)
      3'd0: w_aluctl = bus.func7b50[1] ? 4'd1 : 4'd0;
      3'd1: w_aluctl = 4'd2;
      3'd2: w_aluctl = 4'd3;
      3'd3: w_aluctl = 4'd4;
      3'd4: w_aluctl = 4'd5;
      3'd5: w_aluctl = bus.func7b50[1] ? 4'd7 : 4'd6;
      3'd6: w_aluctl = 4'd8;
      default: w_aluctl = 4'd9;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = w_legal ? S_EX_START : S_TRAP;
      S_EX_START: w_next = |r_ifures ? S_EX_WAIT : S_WB;
      S_EX_WAIT:  w_next = bus.exdone ? S_WB : w_timeout ? S_TRAP : S_EX_WAIT;
      S_WB:       w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluctl    <= '0;
      r_mulctl    <= '0;
      r_ifures    <= '0;
      r_cnt       <= '0;
      r_instret   <= '0;
      r_trapcause <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_aluctl <= w_aluctl;
        r_mulctl <= bus.func3[1:0];
        r_ifures <= IW'(w_mop);
      end
      r_cnt <= r_state == S_EX_WAIT ? r_cnt + 1'b1 : '0;
      if (r_state == S_WB) r_instret <= r_instret + 1'b1;
      if (w_next == S_TRAP && r_state != S_TRAP) r_trapcause <= r_state == S_EX_WAIT;
    end
  end
  assign bus.pcmuxctl  = '0;
  assign bus.pcnextctl = r_state == S_WB;
  assign bus.instrre   = r_state == S_FETCH;
  assign bus.regre     = r_state == S_DECODE;
  assign bus.regwe     = r_state == S_WB;
  assign bus.aluctl    = r_aluctl;
  assign bus.mulstart  = r_state == S_EX_START && |r_ifures;
  assign bus.mulctl    = r_mulctl;
  assign bus.ifuresctl = r_ifures;
  assign bus.trap      = r_state == S_TRAP;
  assign bus.trapcause = r_trapcause;
  assign bus.instret   = r_instret;
endmodule
